// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
// Shared definitions for the instruction-memory loader: FSM state encoding,
// frame header length and the word / byte-index widths used by the loader
// and its byte packer.
package imem_loader_pkg;

  // Loader FSM states. CHK is only reachable when the checksum feature
  // (IMEM_LOADER_CHECKSUM_EN) is compiled in.
  typedef enum logic [2:0] {
    HDR_HI = 3'd0,
    HDR_LO = 3'd1,
    DATA   = 3'd2,
    CHK    = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } loaderState_t;

  // Frame header: 16-bit big-endian word count.
  localparam int HDR_BYTES  = 2;
  // Instruction word width and the index of a byte within a word.
  localparam int WORD_W     = 32;
  localparam int BYTE_IDX_W = 2;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer
// Packs a stream of payload bytes big-endian into 32-bit words and keeps a
// running XOR of every payload byte for the optional frame checksum.
// Ports:
//   CLK       clock, rising edge
//   RST       synchronous active-high reset (clears buffer, index, XOR)
//   byteIn    payload byte
//   byteEn    byteIn is a payload byte accepted on this edge
//   wordOut   word completed by byteIn (valid when wordDone is high)
//   wordDone  byteIn is the 4th byte of a word (combinational pulse)
//   xorSum    XOR of all payload bytes accepted so far
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        byteIn,
  input  logic              byteEn,
  output logic [WORD_W-1:0] wordOut,
  output logic              wordDone,
  output logic [7:0]        xorSum
);

  // Only the three oldest bytes of a word need storing: the fourth byte is
  // taken straight from the input when the word completes, so the write can
  // be registered on the very edge that accepts it.
  logic [WORD_W-9:0]     shiftReg;
  logic [BYTE_IDX_W-1:0] byteIdxReg;

  assign wordOut  = {shiftReg, byteIn};
  assign wordDone = byteEn && (&byteIdxReg);

  always_ff @(posedge CLK) begin
    if (RST) begin
      shiftReg   <= '0;
      byteIdxReg <= '0;
      xorSum     <= 8'h00;
    end else if (byteEn) begin
      shiftReg   <= {shiftReg[WORD_W-17:0], byteIn};
      // Wraps from 3 back to 0 when the word completes.
      byteIdxReg <= byteIdxReg + BYTE_IDX_W'(1);
      xorSum     <= xorSum ^ byteIn;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader
// Serial program loader: receives a framed byte stream (16-bit big-endian
// word count, 4*N payload bytes, optional XOR checksum byte), packs the
// payload into 32-bit words, writes them to consecutive word addresses from
// BASE_ADDR, and holds the CPU stalled until the load completes.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (trailing checksum byte,
// CHK state; a mismatch aborts the load).
// Parameters:
//   BASE_ADDR    byte address of the first written word
//   MAX_WORDS    largest accepted word count; larger headers abort the load
// Ports:
//   CLK          clock, rising edge
//   RST          synchronous active-high reset
//   InByte       stream byte
//   InValid      InByte valid
//   InReady      loader accepts a byte (transfer on InValid && InReady)
//   MemWE        instruction-memory write strobe, one cycle per word
//   MemAddr      word-aligned byte address of the write
//   MemData      word to write
//   CpuHold      stall request for the datapath (released only in DONE)
//   Done         load completed successfully (sticky until RST)
//   Error        load aborted (sticky until RST)
//   LoadedWords  words written so far, saturating
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  InByte,
  input  logic        InValid,
  output logic        InReady,
  output logic        MemWE,
  output logic [31:0] MemAddr,
  output logic [31:0] MemData,
  output logic        CpuHold,
  output logic        Done,
  output logic        Error,
  output logic [15:0] LoadedWords
);

  // State entered once the payload (possibly empty) has been consumed.
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam loaderState_t AFTER_PAYLOAD = CHK;
`else
  localparam loaderState_t AFTER_PAYLOAD = DONE;
`endif

  loaderState_t stateReg;
  loaderState_t stateNext;

  logic [7:0]               countHiReg;
  logic [HDR_BYTES*8-1:0]   countReg;
  logic [HDR_BYTES*8-1:0]   wordIdxReg;
  logic [HDR_BYTES*8-1:0]   headerCount;
  logic                     accept;
  logic                     packEn;
  logic                     wordComplete;
  logic                     lastWord;
  logic [WORD_W-1:0]        packedWord;
  logic [7:0]               xorSum;

  assign accept      = InValid && InReady;
  assign packEn      = accept && (stateReg == DATA);
  assign headerCount = {countHiReg, InByte};
  // Only evaluated in DATA, where countReg is at least 1.
  assign lastWord    = (wordIdxReg == countReg - 16'd1);

  byte_packer packer (
    .CLK      (CLK),
    .RST      (RST),
    .byteIn   (InByte),
    .byteEn   (packEn),
    .wordOut  (packedWord),
    .wordDone (wordComplete),
    .xorSum   (xorSum)
  );

`ifndef IMEM_LOADER_CHECKSUM_EN
  // Without the checksum byte the running XOR has no consumer.
  logic unusedXor;
  assign unusedXor = ^xorSum;
`endif

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stateReg <= HDR_HI;
    end else begin
      stateReg <= stateNext;
    end
  end

  // Next-state logic.
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      HDR_HI: if (accept) stateNext = HDR_LO;
      HDR_LO: begin
        if (accept) begin
          if (int'({16'd0, headerCount}) > MAX_WORDS) begin
            stateNext = ERR;
          end else if (headerCount == '0) begin
            stateNext = AFTER_PAYLOAD;
          end else begin
            stateNext = DATA;
          end
        end
      end
      DATA: if (wordComplete && lastWord) stateNext = AFTER_PAYLOAD;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: if (accept) stateNext = (InByte == xorSum) ? DONE : ERR;
`endif
      default: stateNext = stateReg;  // DONE and ERR leave only through RST
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    InReady = 1'b0;
    CpuHold = 1'b1;
    Done    = 1'b0;
    Error   = 1'b0;
    case (stateReg)
      HDR_HI, HDR_LO, DATA, CHK: InReady = !RST;
      DONE: begin
        CpuHold = 1'b0;
        Done    = 1'b1;
      end
      ERR:     Error = 1'b1;
      default: ;
    endcase
  end

  // Header capture, word index and the registered write port.
  always_ff @(posedge CLK) begin
    if (RST) begin
      countHiReg  <= 8'h00;
      countReg    <= '0;
      wordIdxReg  <= '0;
      MemWE       <= 1'b0;
      MemAddr     <= BASE_ADDR;
      MemData     <= 32'h0000_0000;
      LoadedWords <= 16'h0000;
    end else begin
      MemWE <= 1'b0;
      if (accept && stateReg == HDR_HI) countHiReg <= InByte;
      if (accept && stateReg == HDR_LO) countReg   <= headerCount;
      if (wordComplete) begin
        MemWE      <= 1'b1;
        // 32-bit add wraps silently past the top of the address space.
        MemAddr    <= BASE_ADDR + {14'd0, wordIdxReg, 2'b00};
        MemData    <= packedWord;
        wordIdxReg <= wordIdxReg + 16'd1;
        if (LoadedWords != 16'hFFFF) LoadedWords <= LoadedWords + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MAXW = 256;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CHK_ON = 1'b1;
`else
  localparam bit CHK_ON = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  InByte = 8'h00;
  logic        InValid = 1'b0;
  logic        InReady;
  logic        MemWE;
  logic [31:0] MemAddr;
  logic [31:0] MemData;
  logic        CpuHold;
  logic        Done;
  logic        Error;
  logic [15:0] LoadedWords;

  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .InByte      (InByte),
    .InValid     (InValid),
    .InReady     (InReady),
    .MemWE       (MemWE),
    .MemAddr     (MemAddr),
    .MemData     (MemData),
    .CpuHold     (CpuHold),
    .Done        (Done),
    .Error       (Error),
    .LoadedWords (LoadedWords)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  int cycleCount = 0;
  always @(posedge CLK) cycleCount <= cycleCount + 1;

  // Write monitor, sampled on the falling edge.
  logic [31:0] wAddrQ[$];
  logic [31:0] wDataQ[$];
  logic [15:0] wLoadQ[$];
  int          wCycQ[$];
  logic        prevWE = 1'b0;
  int          doubleWE = 0;
  always @(negedge CLK) begin
    if (!RST && MemWE) begin
      wAddrQ.push_back(MemAddr);
      wDataQ.push_back(MemData);
      wLoadQ.push_back(LoadedWords);
      wCycQ.push_back(cycleCount);
      if (prevWE) doubleWE <= doubleWE + 1;
    end
    prevWE <= MemWE;
  end

  logic [7:0] frameQ[$];
  int         wStart = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic doReset(input string tag);
    @(negedge CLK);
    RST = 1'b1;
    InValid = 1'b0;
    @(negedge CLK);
    check({tag, "_rst_ready"}, 32'(InReady), 32'd0);
    check({tag, "_rst_we"}, 32'(MemWE), 32'd0);
    check({tag, "_rst_addr"}, MemAddr, BASE);
    check({tag, "_rst_data"}, MemData, 32'd0);
    check({tag, "_rst_hold"}, 32'(CpuHold), 32'd1);
    check({tag, "_rst_done"}, 32'(Done), 32'd0);
    check({tag, "_rst_error"}, 32'(Error), 32'd0);
    check({tag, "_rst_loaded"}, 32'(LoadedWords), 32'd0);
    RST = 1'b0;
    #1;
    check({tag, "_ready_after_rst"}, 32'(InReady), 32'd1);
  endtask

  // Offers one byte after 'gap' idle cycles; returns whether it was taken.
  task automatic sendByte(input logic [7:0] b, input int gap, output bit accepted);
    InValid = 1'b0;
    repeat (gap) @(negedge CLK);
    InByte  = b;
    InValid = 1'b1;
    accepted = InReady;
    @(negedge CLK);
    InValid = 1'b0;
  endtask

  // Sends frameQ and checks everything against the frame-level model.
  task automatic runFrame(input int gap, input bit randGap, input string tag);
    int n, expW, expAcc, nAcc, nW, g;
    bit expDone, expErr, acc, d, e, earlyEnd;
    logic [7:0] x;
    logic [31:0] w;
    int accCyc[$];
    n = int'({frameQ[0], frameQ[1]});
    if (n > MAXW) begin
      expW = 0; expAcc = 2; expDone = 1'b0; expErr = 1'b1;
    end else begin
      expW = n;
      x = 8'h00;
      for (int i = 0; i < 4 * n; i++) x ^= frameQ[2 + i];
      if (CHK_ON) begin
        expAcc  = 2 + 4 * n + 1;
        expDone = (frameQ[2 + 4 * n] == x);
      end else begin
        expAcc  = 2 + 4 * n;
        expDone = 1'b1;
      end
      expErr = !expDone;
    end
    wStart = wAddrQ.size();
    nAcc = 0; d = 1'b0; e = 1'b0; earlyEnd = 1'b0;
    foreach (frameQ[i]) begin
      g = randGap ? int'($urandom_range(0, gap)) : gap;
      sendByte(frameQ[i], g, acc);
      if (!acc) break;
      if (d || e) earlyEnd = 1'b1;
      nAcc++;
      accCyc.push_back(cycleCount);
      d = Done;
      e = Error;
    end
    check({tag, "_accepted"}, 32'(nAcc), 32'(expAcc));
    check({tag, "_done_at_end"}, 32'(d), 32'(expDone));
    check({tag, "_error_at_end"}, 32'(e), 32'(expErr));
    check({tag, "_no_early_end"}, 32'(earlyEnd), 32'd0);
    // Keep offering a byte: a terminal loader must not consume it.
    InByte = 8'h5A;
    InValid = 1'b1;
    repeat (3) @(negedge CLK);
    InValid = 1'b0;
    check({tag, "_ready_final"}, 32'(InReady), 32'd0);
    check({tag, "_done"}, 32'(Done), 32'(expDone));
    check({tag, "_error"}, 32'(Error), 32'(expErr));
    check({tag, "_hold"}, 32'(CpuHold), 32'(!expDone));
    check({tag, "_loaded"}, 32'(LoadedWords), 32'(expW));
    nW = wAddrQ.size() - wStart;
    check({tag, "_write_count"}, 32'(nW), 32'(expW));
    check({tag, "_single_cycle_we"}, 32'(doubleWE), 32'd0);
    for (int k = 0; k < expW && k < nW; k++) begin
      w = {frameQ[2 + 4 * k], frameQ[3 + 4 * k], frameQ[4 + 4 * k], frameQ[5 + 4 * k]};
      check({tag, "_addr"}, wAddrQ[wStart + k], BASE + 32'(4 * k));
      check({tag, "_data"}, wDataQ[wStart + k], w);
      check({tag, "_loaded_at_we"}, 32'(wLoadQ[wStart + k]), 32'(k + 1));
      if (5 + 4 * k < accCyc.size())
        check({tag, "_we_latency"}, 32'(wCycQ[wStart + k]), 32'(accCyc[5 + 4 * k]));
    end
    $display("frame %s: header=%0d accepted=%0d writes=%0d done=%0b error=%0b",
             tag, n, nAcc, nW, Done, Error);
  endtask

  typedef struct {
    logic [15:0] hdr;
    int          nSend;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          chkFlip;
    int          gap;
    bit          expDone;
    bit          expError;
    int          expWrites;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [7:0]  x;
    logic [31:0] w;
    bit          acc;
    int          n;

    vecs[0] = '{16'h0002, 2, 32'h2008_0005, 32'h8C09_0004, 1'b0, 0, 1'b1, 1'b0, 2};
    vecs[1] = '{16'h0002, 2, 32'h2008_0005, 32'h8C09_0004, 1'b1, 0, !CHK_ON, CHK_ON, 2};
    vecs[2] = '{16'h0101, 1, 32'h1122_3344, 32'h0, 1'b0, 0, 1'b0, 1'b1, 0};
    vecs[3] = '{16'h0001, 1, 32'hDEAD_BEEF, 32'h0, 1'b0, 3, 1'b1, 1'b0, 1};
    vecs[4] = '{16'h0000, 0, 32'h0, 32'h0, 1'b0, 0, 1'b1, 1'b0, 0};

    for (int v = 0; v < 5; v++) begin
      doReset($sformatf("vec%0d", v));
      frameQ.delete();
      frameQ.push_back(vecs[v].hdr[15:8]);
      frameQ.push_back(vecs[v].hdr[7:0]);
      x = 8'h00;
      for (int k = 0; k < vecs[v].nSend; k++) begin
        w = (k == 0) ? vecs[v].w0 : vecs[v].w1;
        for (int b = 3; b >= 0; b--) begin
          frameQ.push_back(w[8 * b +: 8]);
          x ^= w[8 * b +: 8];
        end
      end
      if (CHK_ON && int'(vecs[v].hdr) <= MAXW) frameQ.push_back(x ^ {7'd0, vecs[v].chkFlip});
      runFrame(vecs[v].gap, 1'b0, $sformatf("vec%0d", v));
      check($sformatf("vec%0d_tbl_done", v), 32'(Done), 32'(vecs[v].expDone));
      check($sformatf("vec%0d_tbl_error", v), 32'(Error), 32'(vecs[v].expError));
      check($sformatf("vec%0d_tbl_writes", v), 32'(wAddrQ.size() - wStart), 32'(vecs[v].expWrites));
    end

    // Reset in the middle of the first word, then a fresh one-word frame.
    doReset("midrst_a");
    sendByte(8'h00, 0, acc);
    sendByte(8'h01, 0, acc);
    sendByte(8'h11, 0, acc);
    sendByte(8'h22, 0, acc);
    doReset("midrst_b");
    frameQ.delete();
    frameQ.push_back(8'h00); frameQ.push_back(8'h01);
    frameQ.push_back(8'hCA); frameQ.push_back(8'hFE);
    frameQ.push_back(8'hF0); frameQ.push_back(8'h0D);
    if (CHK_ON) frameQ.push_back(8'hCA ^ 8'hFE ^ 8'hF0 ^ 8'h0D);
    runFrame(0, 1'b0, "midrst");

    // Randomized frames against the model.
    for (int f = 0; f < 25; f++) begin
      doReset($sformatf("rnd%0d", f));
      n = ($urandom_range(0, 5) == 0) ? MAXW + 1 + int'($urandom_range(0, 200))
                                      : int'($urandom_range(0, 5));
      frameQ.delete();
      frameQ.push_back(8'(n >> 8));
      frameQ.push_back(8'(n));
      x = 8'h00;
      for (int i = 0; i < ((n > MAXW) ? 4 : 4 * n); i++) begin
        frameQ.push_back(8'($urandom));
        x ^= frameQ[frameQ.size() - 1];
      end
      if (CHK_ON && n <= MAXW)
        frameQ.push_back(($urandom_range(0, 3) == 0) ? x ^ 8'($urandom_range(1, 255)) : x);
      runFrame(2, 1'b1, $sformatf("rnd%0d", f));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
